// File: rtl/mdp3_message_streamer.sv
// Collects decoded MDP3 order-book entries and replays them as one Avalon-ST packet:
// a header beat, two beats per entry (fields, then price) and an XOR checksum trailer.
module mdp3_message_streamer #(
    parameter int          MAX_ENTRIES = 4,
    parameter logic [15:0] TEMPLATE_ID = 16'd32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  NUM_ORDERS,
    input  logic [15:0] QUANTITY,
    input  logic [63:0] PRICE,
    input  logic [1:0]  ACTION,
    input  logic [1:0]  ENTRY_TYPE,
    input  logic [31:0] SECURITY_ID,
    input  logic        message_ready,
    input  logic        message_last,
    output logic        streamer_ready,
    input  logic        ready,
    output logic        valid,
    output logic [63:0] data_out,
    output logic        start_packet,
    output logic        end_packet,
    output logic [2:0]  empty
);

    localparam int         AW        = (MAX_ENTRIES > 1) ? $clog2(MAX_ENTRIES) : 1;
    localparam logic [7:0] MAX_COUNT = 8'(MAX_ENTRIES);

    typedef enum logic [2:0] {COLLECT, HEADER, ENTRY_A, ENTRY_B, TRAILER} state_t;

    state_t      state, state_next;
    logic [7:0]  count, count_next;
    logic [7:0]  idx, idx_next, idx_inc;
    logic [31:0] seq_num;
    logic [63:0] acc, acc_next, beat_xor;
    logic        valid_next, start_next, end_next;
    logic [63:0] data_next;
    logic [2:0]  empty_next;
    logic [7:0]  checksum;

    // Entry packing: PRICE[123:60] SECURITY_ID[59:28] QUANTITY[27:12]
    // NUM_ORDERS[11:4] ENTRY_TYPE[3:2] ACTION[1:0]
    logic [123:0]  entry_mem [0:MAX_ENTRIES-1];
    logic [123:0]  wr_entry, rd_entry;
    logic [AW-1:0] rd_addr;
    logic          wr_en;

    assign streamer_ready = (state == COLLECT);
    assign wr_en          = (state == COLLECT) && message_ready;
    assign wr_entry       = {PRICE, SECURITY_ID, QUANTITY, NUM_ORDERS, ENTRY_TYPE, ACTION};
    assign idx_inc        = idx + 8'd1;
    assign beat_xor       = acc ^ data_out;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            entry_mem[count[AW-1:0]] <= wr_entry;
        end
    end

    // The read address looks one beat ahead so the next beat is ready on transfer.
    always_comb begin
        rd_addr = '0;
        case (state)
            ENTRY_A: rd_addr = idx[AW-1:0];
            ENTRY_B: rd_addr = idx_inc[AW-1:0];
            default: rd_addr = '0;
        endcase
    end

    assign rd_entry = entry_mem[rd_addr];

    // Checksum byte folds all eight bytes of the running beat XOR together.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_fold
            assign checksum[gi] = beat_xor[gi]      ^ beat_xor[8 + gi]  ^
                                  beat_xor[16 + gi] ^ beat_xor[24 + gi] ^
                                  beat_xor[32 + gi] ^ beat_xor[40 + gi] ^
                                  beat_xor[48 + gi] ^ beat_xor[56 + gi];
        end
    endgenerate

    always_comb begin
        state_next = state;
        count_next = count;
        idx_next   = idx;
        acc_next   = acc;
        valid_next = valid;
        data_next  = data_out;
        start_next = start_packet;
        end_next   = end_packet;
        empty_next = empty;
        case (state)
            COLLECT: begin
                if (message_ready) begin
                    count_next = count + 8'd1;
                    if (message_last || (count_next == MAX_COUNT)) begin
                        state_next = HEADER;
                        valid_next = 1'b1;
                        start_next = 1'b1;
                        data_next  = {TEMPLATE_ID, count_next, 8'h00, seq_num};
                    end
                end
            end
            HEADER: begin
                if (ready) begin
                    state_next = ENTRY_A;
                    acc_next   = beat_xor;
                    idx_next   = 8'd0;
                    start_next = 1'b0;
                    data_next  = {rd_entry[59:4], 4'h0, rd_entry[3:0]};
                end
            end
            ENTRY_A: begin
                if (ready) begin
                    state_next = ENTRY_B;
                    acc_next   = beat_xor;
                    data_next  = rd_entry[123:60];
                end
            end
            ENTRY_B: begin
                if (ready) begin
                    acc_next = beat_xor;
                    if (idx_inc == count) begin
                        state_next = TRAILER;
                        end_next   = 1'b1;
                        empty_next = 3'd7;
                        data_next  = {checksum, 56'h0};
                    end else begin
                        state_next = ENTRY_A;
                        idx_next   = idx_inc;
                        data_next  = {rd_entry[59:4], 4'h0, rd_entry[3:0]};
                    end
                end
            end
            TRAILER: begin
                if (ready) begin
                    state_next = COLLECT;
                    count_next = 8'd0;
                    idx_next   = 8'd0;
                    acc_next   = 64'd0;
                    valid_next = 1'b0;
                    data_next  = 64'd0;
                    end_next   = 1'b0;
                    empty_next = 3'd0;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= COLLECT;
            count        <= 8'd0;
            idx          <= 8'd0;
            acc          <= 64'd0;
            seq_num      <= 32'd1;
            valid        <= 1'b0;
            data_out     <= 64'd0;
            start_packet <= 1'b0;
            end_packet   <= 1'b0;
            empty        <= 3'd0;
        end else begin
            state        <= state_next;
            count        <= count_next;
            idx          <= idx_next;
            acc          <= acc_next;
            valid        <= valid_next;
            data_out     <= data_next;
            start_packet <= start_next;
            end_packet   <= end_next;
            empty        <= empty_next;
            if (state == TRAILER && ready) begin
                seq_num <= seq_num + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_mdp3_message_streamer.sv
// Bench for mdp3_message_streamer: a queue-based packet model checked every cycle,
// plus literal expectations for the worked single-entry packet and sequence numbers.
module tb_mdp3_message_streamer;

    localparam int MAXE = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  NUM_ORDERS = '0;
    logic [15:0] QUANTITY = '0;
    logic [63:0] PRICE = '0;
    logic [1:0]  ACTION = '0;
    logic [1:0]  ENTRY_TYPE = '0;
    logic [31:0] SECURITY_ID = '0;
    logic        message_ready = 1'b0;
    logic        message_last = 1'b0;
    logic        streamer_ready;
    logic        ready = 1'b1;
    logic        valid;
    logic [63:0] data_out;
    logic        start_packet;
    logic        end_packet;
    logic [2:0]  empty;

    mdp3_message_streamer #(.MAX_ENTRIES(MAXE), .TEMPLATE_ID(16'd32)) dut (
        .clk(clk), .reset(reset),
        .NUM_ORDERS(NUM_ORDERS), .QUANTITY(QUANTITY), .PRICE(PRICE),
        .ACTION(ACTION), .ENTRY_TYPE(ENTRY_TYPE), .SECURITY_ID(SECURITY_ID),
        .message_ready(message_ready), .message_last(message_last),
        .streamer_ready(streamer_ready), .ready(ready), .valid(valid),
        .data_out(data_out), .start_packet(start_packet), .end_packet(end_packet),
        .empty(empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  emp;
    } beat_t;

    beat_t        exp_q[$];
    logic [63:0]  pend_a[$];
    logic [63:0]  pend_b[$];
    logic [63:0]  got_q[$];
    logic [63:0]  hdr_q[$];
    logic [31:0]  seq_m = 32'd1;
    int unsigned  vectors = 0;
    int unsigned  miscompares = 0;
    int unsigned  xfer_cnt = 0;
    int unsigned  sop_seen = 0;
    int unsigned  eop_seen = 0;
    bit           holding = 0;
    beat_t        held;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Build the whole expected packet from the pending entries.
    task automatic build_packet();
        beat_t       b;
        logic [63:0] x;
        logic [7:0]  cks;
        logic [7:0]  n;
        n = 8'(pend_a.size());
        b.data = {16'h0020, n, 8'h00, seq_m};
        b.sop = 1; b.eop = 0; b.emp = 0;
        x = b.data;
        exp_q.push_back(b);
        b.sop = 0;
        for (int i = 0; i < pend_a.size(); i++) begin
            b.data = pend_a[i]; x ^= b.data; exp_q.push_back(b);
            b.data = pend_b[i]; x ^= b.data; exp_q.push_back(b);
        end
        cks = 8'h00;
        for (int k = 0; k < 8; k++) cks ^= x[8*k +: 8];
        b.data = {cks, 56'h0}; b.eop = 1; b.emp = 3'd7;
        exp_q.push_back(b);
        pend_a.delete();
        pend_b.delete();
        seq_m = seq_m + 32'd1;
    endtask

    always @(negedge clk) begin
        bit    was_empty;
        beat_t b;
        if (reset) begin
            exp_q.delete(); pend_a.delete(); pend_b.delete();
            seq_m = 32'd1;
            holding = 0;
        end else begin
            was_empty = (exp_q.size() == 0);
            chk("streamer_ready", {63'd0, streamer_ready}, {63'd0, was_empty});
            chk("valid", {63'd0, valid}, {63'd0, !was_empty});
            if (holding) begin
                chk("hold_data", data_out, held.data);
                chk("hold_flags", {59'd0, start_packet, end_packet, empty},
                    {59'd0, held.sop, held.eop, held.emp});
            end
            holding = 0;
            if (!was_empty && ready) begin
                b = exp_q.pop_front();
                chk("beat_data", data_out, b.data);
                chk("beat_flags", {59'd0, start_packet, end_packet, empty},
                    {59'd0, b.sop, b.eop, b.emp});
                got_q.push_back(data_out);
                if (b.sop) hdr_q.push_back(data_out);
                if (start_packet) sop_seen++;
                if (end_packet) eop_seen++;
                xfer_cnt++;
                $display("beat %0d data=%h sop=%0b eop=%0b empty=%0d",
                         xfer_cnt, data_out, start_packet, end_packet, empty);
            end else if (!was_empty) begin
                holding = 1;
                held.data = data_out; held.sop = start_packet;
                held.eop = end_packet; held.emp = empty;
            end
            if (was_empty && message_ready) begin
                pend_a.push_back({SECURITY_ID, QUANTITY, NUM_ORDERS, 4'h0, ENTRY_TYPE, ACTION});
                pend_b.push_back(PRICE);
                if (message_last || pend_a.size() == MAXE) build_packet();
            end
        end
    end

    task automatic put(input logic [31:0] sid, input logic [15:0] qty, input logic [7:0] no,
                       input logic [1:0] act, input logic [1:0] et, input logic [63:0] price,
                       input logic last);
        SECURITY_ID = sid; QUANTITY = qty; NUM_ORDERS = no; ACTION = act;
        ENTRY_TYPE = et; PRICE = price; message_last = last; message_ready = 1'b1;
        @(posedge clk); #1;
        message_ready = 1'b0; message_last = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && pend_a.size() == 0) done = 1;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL wait_idle: packet still outstanding after %0d cycles", budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, valid}, 64'd0);
        chk("rst_data", data_out, 64'd0);
        chk("rst_streamer_ready", {63'd0, streamer_ready}, 64'd1);
        chk("rst_flags", {59'd0, start_packet, end_packet, empty}, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Worked single-entry packet
        put(32'h0000_1234, 16'h0010, 8'd3, 2'd1, 2'd2, 64'h0000_0000_0001_86A0, 1'b1);
        wait_idle(20);
        chk("lit_len", 64'(got_q.size()), 64'd4);
        if (got_q.size() >= 4) begin
            chk("lit_header", got_q[0], 64'h0020_0100_0000_0001);
            chk("lit_entry_a", got_q[1], 64'h0000_1234_0010_0309);
            chk("lit_entry_b", got_q[2], 64'h0000_0000_0001_86A0);
            chk("lit_trailer", got_q[3], 64'h3B00_0000_0000_0000);
        end

        // Two more packets for sequence numbering
        put(32'hAAAA_0001, 16'h0001, 8'd1, 2'd0, 2'd1, 64'h1111_2222_3333_4444, 1'b1);
        wait_idle(20);
        put(32'hBBBB_0002, 16'hFFFF, 8'd255, 2'd3, 2'd3, 64'hFFFF_0000_FFFF_0000, 1'b1);
        wait_idle(20);
        chk("seq_count", 64'(hdr_q.size()), 64'd3);
        if (hdr_q.size() >= 3) begin
            chk("seq_1", {32'd0, hdr_q[0][31:0]}, 64'd1);
            chk("seq_2", {32'd0, hdr_q[1][31:0]}, 64'd2);
            chk("seq_3", {32'd0, hdr_q[2][31:0]}, 64'd3);
        end

        // Buffer fill: four entries without message_last
        for (int i = 0; i < 4; i++)
            put(32'h0100_0000 + 32'(i), 16'(i * 7), 8'(i), 2'(i), 2'(3 - i),
                64'h0123_4567_89AB_CDEF ^ 64'(i), 1'b0);
        wait_idle(30);
        chk("fill_count", {56'd0, hdr_q[hdr_q.size() - 1][47:40]}, 64'd4);

        // Back-pressure over a 2-entry packet
        sop_seen = 0; eop_seen = 0;
        put(32'hCAFE_0001, 16'h0100, 8'd9, 2'd2, 2'd0, 64'hDEAD_BEEF_0000_0001, 1'b0);
        put(32'hCAFE_0002, 16'h0200, 8'd8, 2'd1, 2'd1, 64'hDEAD_BEEF_0000_0002, 1'b1);
        ready = 1'b0;
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge clk); #1;
            ready = ~ready;
        end
        ready = 1'b1;
        wait_idle(20);
        chk("bp_sop_count", 64'(sop_seen), 64'd1);
        chk("bp_eop_count", 64'(eop_seen), 64'd1);

        // Sequence wrap via forced counter
        force dut.seq_num = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        release dut.seq_num;
        seq_m = 32'hFFFF_FFFF;
        put(32'h0000_0F0F, 16'h0F0F, 8'd15, 2'd1, 2'd1, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1);
        wait_idle(20);
        put(32'h0000_F0F0, 16'hF0F0, 8'd240, 2'd2, 2'd2, 64'hF0F0_F0F0_F0F0_F0F0, 1'b1);
        wait_idle(20);
        chk("wrap_ffffffff", {32'd0, hdr_q[hdr_q.size() - 2][31:0]}, 64'hFFFF_FFFF);
        chk("wrap_zero", {32'd0, hdr_q[hdr_q.size() - 1][31:0]}, 64'd0);

        // Reset during the first ENTRY_B beat of a 2-entry packet
        xfer_cnt = 0;
        put(32'h5555_0001, 16'h0005, 8'd5, 2'd1, 2'd0, 64'h5555_5555_5555_5555, 1'b0);
        put(32'h5555_0002, 16'h0006, 8'd6, 2'd0, 2'd1, 64'h6666_6666_6666_6666, 1'b1);
        for (int i = 0; i < 20 && xfer_cnt < 2; i++) @(posedge clk);
        #1;
        chk("rst_reached_entry_b", 64'(xfer_cnt), 64'd2);
        reset = 1'b1;
        #1;
        chk("rst_async_valid", {63'd0, valid}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        put(32'h7777_0001, 16'h0077, 8'd7, 2'd3, 2'd2, 64'h7777_0000_0000_7777, 1'b1);
        wait_idle(20);
        chk("post_rst_seq", {32'd0, hdr_q[hdr_q.size() - 1][31:0]}, 64'd1);
        chk("post_rst_count", {56'd0, hdr_q[hdr_q.size() - 1][47:40]}, 64'd1);

        // message_ready held high across emission with changing data
        SECURITY_ID = 32'h9000_0000; QUANTITY = 16'h0009; NUM_ORDERS = 8'd2;
        ACTION = 2'd1; ENTRY_TYPE = 2'd1; PRICE = 64'h9999_0000_0000_0001;
        message_last = 1'b1; message_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk); #1;
            SECURITY_ID = SECURITY_ID + 32'd1;
            PRICE = PRICE + 64'd1;
        end
        message_ready = 1'b0; message_last = 1'b0;
        wait_idle(30);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
